multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 144 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with
// an illegal-opcode trap and a retired-instruction counter.
module multicycle_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        branch_cond,
   input  logic        imem_valid,
   input  logic        dmem_ready,
   input  logic        stall,
   output logic        imem_req,
   output logic        ir_write,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        retired,
   output logic [31:0] instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [2:0]  state_q;
   logic [2:0]  state_d;
   logic [6:0]  op_q;
   logic        illegal_q;
   logic [31:0] instret_q;

   function automatic logic is_supported(input logic [6:0] op);
      logic ok;
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
         default:                           ok = 1'b0;
      endcase
      return ok;
   endfunction

   always_comb begin
      state_d   = state_q;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      retired   = 1'b0;
      // Everything is forced quiet while reset is held, regardless of state_q.
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = !stall;
               if (imem_valid && !stall) begin
                  ir_write = 1'b1;
                  state_d  = S_DECODE;
               end
            end
            S_DECODE: state_d = is_supported(opcode) ? S_EXEC : S_TRAP;
            S_EXEC: begin
               case (op_q)
                  OP_BRANCH: begin
                     pc_write = 1'b1;
                     pc_src   = branch_cond ? 2'b01 : 2'b00;
                     retired  = 1'b1;
                     state_d  = S_FETCH;
                  end
                  OP_JAL, OP_JALR: begin
                     reg_write = 1'b1;
                     wb_sel    = 2'b10;
                     pc_write  = 1'b1;
                     pc_src    = (op_q == OP_JAL) ? 2'b10 : 2'b11;
                     retired   = 1'b1;
                     state_d   = S_FETCH;
                  end
                  OP_LOAD, OP_STORE: state_d = S_MEM;
                  default:           state_d = S_WB;
               endcase
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (op_q == OP_STORE);
               if (dmem_ready) begin
                  if (op_q == OP_STORE) begin
                     pc_write = 1'b1;
                     retired  = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end
            end
            S_WB: begin
               reg_write = 1'b1;
               wb_sel    = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
               pc_write  = 1'b1;
               retired   = 1'b1;
               state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= 7'd0;
         illegal_q <= 1'b0;
         instret_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (state_d == S_TRAP) illegal_q <= 1'b1;
         if (retired) instret_q <= instret_q + 32'd1;
      end
   end

   assign state   = rst ? 3'd0  : state_q;
   assign illegal = rst ? 1'b0  : illegal_q;
   assign instret = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-lifecycle reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic        branch_cond = 1'b0;
   logic        imem_valid = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, illegal, retired;
   logic [1:0]  wb_sel, pc_src;
   logic [2:0]  state;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond),
      .imem_valid(imem_valid), .dmem_ready(dmem_ready), .stall(stall),
      .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
      .state(state), .illegal(illegal), .retired(retired), .instret(instret)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Instruction classes
   function automatic bit f_sup(input logic [6:0] o);
      return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                       7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   endfunction
   function automatic bit f_load(input logic [6:0] o);   return o == 7'b0000011; endfunction
   function automatic bit f_store(input logic [6:0] o);  return o == 7'b0100011; endfunction
   function automatic bit f_mem(input logic [6:0] o);    return f_load(o) || f_store(o); endfunction
   function automatic bit f_branch(input logic [6:0] o); return o == 7'b1100011; endfunction
   function automatic bit f_jump(input logic [6:0] o);   return o == 7'b1101111 || o == 7'b1100111; endfunction

   // Model: m_pos counts cycles spent on the current instruction (0 = fetching).
   int          m_pos = 0;
   logic [6:0]  m_op = 7'd0;
   bit          m_trap = 1'b0;
   logic [31:0] m_instret = 32'd0;
   bit          chk_en = 1'b0;
   bit          preload_req = 1'b0;

   logic        e_imem_req, e_ir_write, e_dmem_req, e_dmem_we, e_reg_write, e_pc_write;
   logic        e_illegal, e_retired, wb_step;
   logic [1:0]  e_wb_sel, e_pc_src;
   logic [2:0]  e_state;
   logic [31:0] e_instret;

   always_comb begin
      e_state = 3'd0; e_imem_req = 1'b0; e_ir_write = 1'b0; e_dmem_req = 1'b0;
      e_dmem_we = 1'b0; e_reg_write = 1'b0; e_wb_sel = 2'd0; e_pc_write = 1'b0;
      e_pc_src = 2'd0; e_illegal = 1'b0; e_retired = 1'b0; e_instret = 32'd0;
      wb_step = 1'b0;
      if (!rst) begin
         e_instret = m_instret;
         e_illegal = m_trap;
         wb_step = !m_trap && (m_pos == 4 || (m_pos == 3 && !f_mem(m_op)));
         if (m_trap) begin
            e_state = 3'd5;
         end else if (m_pos == 0) begin
            e_imem_req = !stall;
            e_ir_write = imem_valid && !stall;
         end else if (m_pos == 1) begin
            e_state = 3'd1;
         end else if (m_pos == 2) begin
            e_state = 3'd2;
            if (f_branch(m_op)) begin
               e_pc_write = 1'b1; e_pc_src = branch_cond ? 2'd1 : 2'd0; e_retired = 1'b1;
            end else if (f_jump(m_op)) begin
               e_reg_write = 1'b1; e_wb_sel = 2'd2; e_pc_write = 1'b1; e_retired = 1'b1;
               e_pc_src = (m_op == 7'b1101111) ? 2'd2 : 2'd3;
            end
         end else if (wb_step) begin
            e_state = 3'd4; e_reg_write = 1'b1; e_pc_write = 1'b1; e_retired = 1'b1;
            e_wb_sel = f_load(m_op) ? 2'd1 : 2'd0;
         end else begin
            e_state = 3'd3; e_dmem_req = 1'b1; e_dmem_we = f_store(m_op);
            if (dmem_ready && f_store(m_op)) begin
               e_pc_write = 1'b1; e_retired = 1'b1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         m_pos <= 0; m_op <= 7'd0; m_trap <= 1'b0; m_instret <= 32'd0;
      end else begin
         if (e_retired) begin
            m_pos <= 0;
            m_instret <= m_instret + 32'd1;
         end else if (!m_trap) begin
            case (m_pos)
               0: if (imem_valid && !stall) m_pos <= 1;
               1: begin
                  m_op <= opcode;
                  if (f_sup(opcode)) m_pos <= 2;
                  else m_trap <= 1'b1;
               end
               2: m_pos <= 3;
               3: if (dmem_ready) m_pos <= 4;
               default: ;
            endcase
         end
         if (preload_req) m_instret <= 32'hFFFF_FFFF;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("state", {29'd0, state}, {29'd0, e_state});
         chk("imem_req", {31'd0, imem_req}, {31'd0, e_imem_req});
         chk("ir_write", {31'd0, ir_write}, {31'd0, e_ir_write});
         chk("dmem_req", {31'd0, dmem_req}, {31'd0, e_dmem_req});
         chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_dmem_we});
         chk("reg_write", {31'd0, reg_write}, {31'd0, e_reg_write});
         chk("wb_sel", {30'd0, wb_sel}, {30'd0, e_wb_sel});
         chk("pc_write", {31'd0, pc_write}, {31'd0, e_pc_write});
         chk("pc_src", {30'd0, pc_src}, {30'd0, e_pc_src});
         chk("illegal", {31'd0, illegal}, {31'd0, e_illegal});
         chk("retired", {31'd0, retired}, {31'd0, e_retired});
         chk("instret", instret, e_instret);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [6:0] pool [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   initial begin
      int k;
      // Reset
      cyc();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_instret", instret, 32'd0);
      cyc();
      rst = 1'b0; stall = 1'b0;

      // R-type, zero-wait
      for (int c = 1; c <= 4; c++) begin
         opcode = 7'b0110011; imem_valid = 1'b1; dmem_ready = 1'b1;
         @(negedge clk);
         chk("r_state", {29'd0, state}, (c == 4) ? 32'd4 : 32'(c - 1));
         if (c == 1) chk("r_imem_req_after_rst", {31'd0, imem_req}, 32'd1);
         if (c == 4) begin
            chk("r_reg_write", {31'd0, reg_write}, 32'd1);
            chk("r_retired", {31'd0, retired}, 32'd1);
            chk("r_wb_sel", {30'd0, wb_sel}, 32'd0);
         end
         cyc();
      end

      // Load with three wait cycles in MEM
      for (int c = 1; c <= 8; c++) begin
         opcode = 7'b0000011; imem_valid = 1'b1; dmem_ready = (c < 4) || (c == 7);
         @(negedge clk);
         if (c == 1) chk("r_instret", instret, 32'd1);
         if (c >= 4 && c <= 7) begin
            chk("ld_state", {29'd0, state}, 32'd3);
            chk("ld_dmem_req", {31'd0, dmem_req}, 32'd1);
            chk("ld_dmem_we", {31'd0, dmem_we}, 32'd0);
         end
         if (c == 8) begin
            chk("ld_wb_state", {29'd0, state}, 32'd4);
            chk("ld_wb_sel", {30'd0, wb_sel}, 32'd1);
            chk("ld_retired", {31'd0, retired}, 32'd1);
         end
         cyc();
      end

      // Branch taken then not taken
      for (int t = 1; t >= 0; t--) begin
         for (int c = 1; c <= 3; c++) begin
            opcode = 7'b1100011; branch_cond = (c == 3) ? t[0] : !t[0];
            @(negedge clk);
            chk("br_reg_write", {31'd0, reg_write}, 32'd0);
            if (c == 3) begin
               chk("br_state", {29'd0, state}, 32'd2);
               chk("br_pc_src", {30'd0, pc_src}, (t == 1) ? 32'd1 : 32'd0);
               chk("br_retired", {31'd0, retired}, 32'd1);
            end
            cyc();
         end
      end

      // Stall beats imem_valid in FETCH; ignored elsewhere
      for (int c = 1; c <= 6; c++) begin
         opcode = 7'b0110111; imem_valid = 1'b1; stall = (c != 3);
         @(negedge clk);
         if (c <= 2) begin
            chk("st_imem_req", {31'd0, imem_req}, 32'd0);
            chk("st_ir_write", {31'd0, ir_write}, 32'd0);
            chk("st_state", {29'd0, state}, 32'd0);
         end
         if (c == 3) chk("st_ir_write_drop", {31'd0, ir_write}, 32'd1);
         if (c == 4) chk("st_decode", {29'd0, state}, 32'd1);
         if (c == 6) chk("st_retired", {31'd0, retired}, 32'd1);
         cyc();
      end
      stall = 1'b0;

      // Unsupported opcode traps until reset
      for (int c = 1; c <= 24; c++) begin
         opcode = 7'b1110011; imem_valid = (c != 24); rst = (c == 23);
         @(negedge clk);
         if (c >= 3 && c <= 22) begin
            chk("trap_state", {29'd0, state}, 32'd5);
            chk("trap_illegal", {31'd0, illegal}, 32'd1);
            chk("trap_imem_req", {31'd0, imem_req}, 32'd0);
         end
         if (c == 24) begin
            chk("trap_rst_state", {29'd0, state}, 32'd0);
            chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
            chk("trap_rst_instret", instret, 32'd0);
         end
         cyc();
      end
      rst = 1'b0;

      // Counter wrap: preload all-ones while stalled in FETCH
      chk_en = 1'b0; stall = 1'b1; imem_valid = 1'b0; preload_req = 1'b1;
      force dut.instret_q = 32'hFFFF_FFFF;
      cyc();
      release dut.instret_q;
      preload_req = 1'b0; chk_en = 1'b1; stall = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         opcode = 7'b1100011; imem_valid = 1'b1; branch_cond = 1'b0;
         @(negedge clk);
         if (c == 1) chk("wrap_pre", instret, 32'hFFFF_FFFF);
         cyc();
      end

      // Store stuck in MEM, then reset
      for (int c = 1; c <= 6; c++) begin
         opcode = 7'b0100011; imem_valid = (c == 1); dmem_ready = 1'b0; rst = (c == 5);
         @(negedge clk);
         if (c == 1) chk("wrap_post", instret, 32'd0);
         if (c == 4) begin
            chk("sw_state", {29'd0, state}, 32'd3);
            chk("sw_dmem_we", {31'd0, dmem_we}, 32'd1);
         end
         if (c == 6) chk("sw_rst_state", {29'd0, state}, 32'd0);
         cyc();
      end
      rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(149) == 0) || (m_trap && $urandom_range(7) == 0);
         k = int'($urandom_range(11));
         if (k < 9) opcode = pool[k];
         else if (k == 9) opcode = 7'b1110011;
         else opcode = 7'($urandom_range(127));
         imem_valid  = $urandom_range(9) < 7;
         stall       = $urandom_range(9) < 2;
         dmem_ready  = 1'($urandom_range(1));
         branch_cond = 1'($urandom_range(1));
         cyc();
      end
      rst = 1'b0; stall = 1'b0;
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
